ldpc_frame_loader: RTL

Upstream stage of the QC-LDPC syndrome validator. It accepts a hard-decision codeword as a valid/ready bit stream and packs it into the validator's block-slotted codeword layout. It then runs one validator transaction over the `start`/`ready` handshake and returns a single pass/fail/error result per frame. The loader holds the packed codeword stable for the whole validation.

---
 rtl/ldpc_frame_loader_pkg.sv | 30 +++
 rtl/ldpc_bit_packer.sv | 64 ++++++
 rtl/ldpc_frame_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_frame_loader_pkg.sv
// Shared definitions for the LDPC frame loader: one-hot FSM encoding and
// width helpers that size the codeword buffer, bit pointer and column pointer
// identically to the downstream syndrome validator.
package ldpc_frame_loader_pkg;

   typedef enum logic [5:0] {
      ST_IDLE  = 6'b000001,
      ST_FILL  = 6'b000010,
      ST_DRAIN = 6'b000100,
      ST_HAND  = 6'b001000,
      ST_WAIT  = 6'b010000,
      ST_RES   = 6'b100000
   } state_t;

   // Total packed codeword width (all block slots).
   function automatic int code_len(input int max_block_size, input int max_cols);
      return max_block_size * max_cols;
   endfunction

   // Width of the in-block bit index / block_size field (at least 1 bit).
   function automatic int blk_w(input int max_block_size);
      return (max_block_size > 1) ? $clog2(max_block_size) : 1;
   endfunction

   // Width of the column count field; must be able to hold max_cols itself.
   function automatic int col_w(input int max_cols);
      return $clog2(max_cols + 1);
   endfunction

endpackage

// File: rtl/ldpc_bit_packer.sv
// Purpose: maps one IN_WIDTH beat onto the block-slotted codeword buffer.
// Latency: combinational. Backpressure: none; the caller decides when to commit.
// Ports: data/col/bit_pos/block_size/cols in; wr_mask/wr_data/col_next/bit_next/reached_l out.
module ldpc_bit_packer
   import ldpc_frame_loader_pkg::*;
#(
   parameter int MAX_BLOCK_SIZE = 8,
   parameter int MAX_COLS       = 8,
   parameter int IN_WIDTH       = 4,
   localparam int BW    = blk_w(MAX_BLOCK_SIZE),
   localparam int CW    = col_w(MAX_COLS),
   localparam int LEN   = code_len(MAX_BLOCK_SIZE, MAX_COLS),
   localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
   input  logic [IN_WIDTH-1:0] data,
   input  logic [CW-1:0]       col,
   input  logic [BW-1:0]       bit_pos,
   input  logic [BW-1:0]       block_size,
   input  logic [CW-1:0]       cols,
   output logic [LEN-1:0]      wr_mask,
   output logic [LEN-1:0]      wr_data,
   output logic [CW-1:0]       col_next,
   output logic [BW-1:0]       bit_next,
   output logic                reached_l
);

   // Walk the beat LSB first. Once bit L-1 has been placed, the remaining
   // beat bits are dropped and the pointer stops advancing.
   always_comb begin
      int   c;
      int   k;
      logic done;
      logic [IDX_W-1:0] idx;
      wr_mask = '0;
      wr_data = '0;
      c       = int'(col);
      k       = int'(bit_pos);
      done    = 1'b0;
      idx     = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (!done) begin
            // Range guard keeps an out-of-range pointer from aliasing into
            // another slot; legal configurations never trip it.
            if (c < MAX_COLS && k < MAX_BLOCK_SIZE) begin
               idx          = IDX_W'(c * MAX_BLOCK_SIZE + k);
               wr_mask[idx] = 1'b1;
               wr_data[idx] = data[i];
            end
            if (c == int'(cols) - 1 && k == int'(block_size) - 1) begin
               done = 1'b1;
            end else if (k >= int'(block_size) - 1) begin
               k = 0;
               c = c + 1;
            end else begin
               k = k + 1;
            end
         end
      end
      col_next  = CW'(c);
      bit_next  = BW'(k);
      reached_l = done;
   end

endmodule

// File: rtl/ldpc_frame_loader.sv
// Purpose: packs a valid/ready codeword bit stream into the validator layout,
//   runs one validator transaction and reports pass/fail/error per frame.
// Latency: closing beat -> val_start 1 cycle (val_ready high); val_ready high -> res_valid 1 cycle.
// Backpressure: s_ready high only in IDLE/FILL/DRAIN; one frame in flight.
// Ports: s_valid/s_ready/s_data/s_last/block_size_in/cols_in stream in;
//   codeword_out/val_start/val_ready/val_valid validator side; res_valid/res_pass/res_error result.
// Option: define LDPC_LOADER_LEN_CHECK_EN to enforce s_last on the beat holding bit L-1.
module ldpc_frame_loader
   import ldpc_frame_loader_pkg::*;
#(
   parameter int MAX_BLOCK_SIZE = 8,
   parameter int MAX_COLS       = 8,
   parameter int IN_WIDTH       = 4,
   localparam int BW  = blk_w(MAX_BLOCK_SIZE),
   localparam int CW  = col_w(MAX_COLS),
   localparam int LEN = code_len(MAX_BLOCK_SIZE, MAX_COLS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [IN_WIDTH-1:0] s_data,
   input  logic                s_last,
   input  logic [BW-1:0]       block_size_in,
   input  logic [CW-1:0]       cols_in,
   output logic [LEN-1:0]      codeword_out,
   output logic                val_start,
   input  logic                val_ready,
   input  logic                val_valid,
   output logic                res_valid,
   output logic                res_pass,
   output logic                res_error
);

   state_t         state_q, state_d;
   logic [BW-1:0]  cfg_bs_q;
   logic [CW-1:0]  cfg_cols_q;
   logic [CW-1:0]  col_q;
   logic [BW-1:0]  bit_q;
   logic [LEN-1:0] cw_q;
   logic           err_q;
   logic           pass_q;
   logic           low_seen_q;

   logic           in_idle;
   logic           cfg_ok;
   logic [BW-1:0]  cur_bs;
   logic [CW-1:0]  cur_cols;
   logic [CW-1:0]  cur_col;
   logic [BW-1:0]  cur_bit;
   logic [LEN-1:0] wr_mask, wr_data;
   logic [CW-1:0]  col_next;
   logic [BW-1:0]  bit_next;
   logic           reached_l;

   logic           frame_start;
   logic           write_en;
   logic           err_set;
   logic           capture;
   state_t         close_state;
   logic           close_err;

   // In IDLE the first beat is packed with the live configuration and a
   // zero pointer, so no cycle is lost latching the configuration first.
   assign in_idle  = (state_q == ST_IDLE);
   assign cur_bs   = in_idle ? block_size_in : cfg_bs_q;
   assign cur_cols = in_idle ? cols_in       : cfg_cols_q;
   assign cur_col  = in_idle ? '0            : col_q;
   assign cur_bit  = in_idle ? '0            : bit_q;
   assign cfg_ok   = (block_size_in != '0) && (cols_in != '0) && (int'(cols_in) <= MAX_COLS);

   ldpc_bit_packer #(
      .MAX_BLOCK_SIZE (MAX_BLOCK_SIZE),
      .MAX_COLS       (MAX_COLS),
      .IN_WIDTH       (IN_WIDTH)
   ) u_packer (
      .data       (s_data),
      .col        (cur_col),
      .bit_pos    (cur_bit),
      .block_size (cur_bs),
      .cols       (cur_cols),
      .wr_mask    (wr_mask),
      .wr_data    (wr_data),
      .col_next   (col_next),
      .bit_next   (bit_next),
      .reached_l  (reached_l)
   );

   // Where an accepted data beat of a legal frame leads.
   always_comb begin
      close_state = ST_FILL;
      close_err   = 1'b0;
`ifdef LDPC_LOADER_LEN_CHECK_EN
      if (reached_l) begin
         if (s_last) begin
            close_state = ST_HAND;
         end else begin
            close_err   = 1'b1;
            close_state = ST_DRAIN;
         end
      end else if (s_last) begin
         close_err   = 1'b1;
         close_state = ST_RES;
      end
`else
      if (reached_l) begin
         close_state = ST_HAND;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      s_ready     = 1'b0;
      val_start   = 1'b0;
      res_valid   = 1'b0;
      frame_start = 1'b0;
      write_en    = 1'b0;
      err_set     = 1'b0;
      capture     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               frame_start = 1'b1;
               if (!cfg_ok) begin
                  err_set = 1'b1;
                  state_d = s_last ? ST_RES : ST_DRAIN;
               end else begin
                  write_en = 1'b1;
                  err_set  = close_err;
                  state_d  = close_state;
               end
            end
         end
         ST_FILL: begin
            s_ready = 1'b1;
            if (s_valid) begin
               write_en = 1'b1;
               err_set  = close_err;
               state_d  = close_state;
            end
         end
         ST_DRAIN: begin
            s_ready = 1'b1;
            if (s_valid && s_last) begin
               state_d = ST_RES;
            end
         end
         ST_HAND: begin
            if (val_ready) begin
               val_start = 1'b1;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // The validator must first drop ready (busy) before its next
            // ready edge is taken as completion.
            if (low_seen_q && val_ready) begin
               capture = 1'b1;
               state_d = ST_RES;
            end
         end
         ST_RES: begin
            res_valid = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_bs_q   <= '0;
         cfg_cols_q <= '0;
         col_q      <= '0;
         bit_q      <= '0;
         cw_q       <= '0;
         err_q      <= 1'b0;
         pass_q     <= 1'b0;
         low_seen_q <= 1'b0;
      end else begin
         if (frame_start) begin
            cfg_bs_q   <= block_size_in;
            cfg_cols_q <= cols_in;
         end
         if (write_en) begin
            col_q <= col_next;
            bit_q <= bit_next;
         end
         // A new frame starts from a clean buffer so unwritten slot bits read 0.
         if (frame_start) begin
            cw_q <= write_en ? (wr_data & wr_mask) : '0;
         end else if (write_en) begin
            cw_q <= (cw_q & ~wr_mask) | (wr_data & wr_mask);
         end
         if (frame_start) begin
            err_q <= err_set;
         end else if (err_set) begin
            err_q <= 1'b1;
         end
         if (frame_start) begin
            pass_q <= 1'b0;
         end else if (capture) begin
            pass_q <= val_valid;
         end
         if (state_q == ST_HAND) begin
            low_seen_q <= 1'b0;
         end else if (state_q == ST_WAIT && !val_ready) begin
            low_seen_q <= 1'b1;
         end
      end
   end

   assign codeword_out = cw_q;
   assign res_pass     = pass_q;
   assign res_error    = err_q;

endmodule
